// File: rtl/rvfi_multi_commit_monitor.sv
// Commit tracker for multi-lane RVFI retire ports: lane contiguity, order sequencing, halt, watchdog, segment counters.
// Define RVFI_COMMIT_LOG_EN for a simulation-only console trace of accepted lanes.
module rvfi_multi_commit_monitor #(
  parameter int unsigned NRET      = 2,
  parameter int unsigned ORDER_W   = 64,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned WDOG_CYC  = 10000,
  parameter logic [31:0] SEG_START = 32'h00102013,
  parameter logic [31:0] SEG_STOP  = 32'h00202013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRET-1:0]           valid,
  input  logic [NRET*ORDER_W-1:0]   order,
  input  logic [NRET*32-1:0]        inst,
  input  logic [NRET*32-1:0]        pc_rdata,
  input  logic [NRET*32-1:0]        pc_wdata,
  output logic                      halt,
  output logic                      error,
  output logic [2:0]                err_code,
  output logic [1:0]                seg_state,
  output logic [CNT_W-1:0]          inst_count,
  output logic [CNT_W-1:0]          cycle_count
);

  typedef enum logic [1:0] {
    SEG_FREE   = 2'd0,
    SEG_ACTIVE = 2'd1,
    SEG_DONE   = 2'd2
  } seg_e;

  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
  localparam logic [ORDER_W-1:0] ORDER_ONE = 1;

  function automatic logic halt_cond(input logic [31:0] i, input logic [31:0] pr,
                                     input logic [31:0] pw);
    return (pr == pw) || (i == 32'h0000_0063) || (i == 32'h0000_006f) ||
           (i == 32'hF000_2013);
  endfunction

  seg_e               seg_q, seg_n;
  logic [ORDER_W-1:0] exp_order, exp_n, rank;
  logic [CNT_W-1:0]   inst_n, cyc_n;
  logic [31:0]        wdog, wdog_n;
  logic [NRET-1:0]    accept;
  logic               halt_hit, seen_idle;
  logic               gap_err, ord_err, wdog_err, post_halt_err;
  logic [2:0]         code_n;

  // Lanes are walked oldest first; each accepted lane updates the running
  // segment/counter view so start/stop markers in one cycle resolve in order.
  // NOTE: blocking assignments here model the in-cycle lane sequence; every
  // variable gets a default first so no latch is inferred.
  always_comb begin
    accept        = '0;
    halt_hit      = 1'b0;
    seen_idle     = 1'b0;
    gap_err       = 1'b0;
    ord_err       = 1'b0;
    wdog_err      = 1'b0;
    post_halt_err = 1'b0;
    rank          = '0;
    seg_n         = seg_q;
    inst_n        = inst_count;
    cyc_n         = cycle_count;
    exp_n         = exp_order;
    wdog_n        = wdog;
    if (halt) begin
      post_halt_err = |valid;
    end else begin
      if (seg_q != SEG_DONE) cyc_n = cycle_count + CNT_ONE;
      for (int k = 0; k < NRET; k++) begin
        if (!halt_hit) begin
          if (valid[k]) begin
            accept[k] = 1'b1;
            if (seen_idle) gap_err = 1'b1;
            if (order[k*ORDER_W +: ORDER_W] != exp_order + rank) ord_err = 1'b1;
            rank = rank + ORDER_ONE;
            if (inst[k*32 +: 32] == SEG_START) begin
              seg_n  = SEG_ACTIVE;
              cyc_n  = '0;
              inst_n = '0;
            end else if (inst[k*32 +: 32] == SEG_STOP && seg_n == SEG_ACTIVE) begin
              inst_n = inst_n + CNT_ONE;
              seg_n  = SEG_DONE;
            end else if (seg_n != SEG_DONE) begin
              inst_n = inst_n + CNT_ONE;
            end
            if (halt_cond(inst[k*32 +: 32], pc_rdata[k*32 +: 32], pc_wdata[k*32 +: 32]))
              halt_hit = 1'b1;
          end else begin
            seen_idle = 1'b1;
          end
        end
      end
      exp_n = exp_order + rank;
      // Watchdog saturates at its limit so a long stall cannot wrap back to quiet.
      if (|valid) begin
        wdog_n = '0;
      end else if (WDOG_CYC != 0 && wdog < WDOG_CYC) begin
        wdog_n = wdog + 32'd1;
      end
      if (WDOG_CYC != 0 && wdog_n == WDOG_CYC) wdog_err = 1'b1;
    end

    if (gap_err)            code_n = 3'd1;
    else if (ord_err)       code_n = 3'd2;
    else if (wdog_err)      code_n = 3'd3;
    else if (post_halt_err) code_n = 3'd4;
    else                    code_n = 3'd0;
  end

  // NOTE: sequential state uses non-blocking assignments; the synchronous reset
  // restores every register, including mid-segment.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 3'd0;
      seg_q       <= SEG_FREE;
      inst_count  <= '0;
      cycle_count <= '0;
      exp_order   <= '0;
      wdog        <= '0;
    end else begin
      halt        <= halt | halt_hit;
      seg_q       <= seg_n;
      inst_count  <= inst_n;
      cycle_count <= cyc_n;
      exp_order   <= exp_n;
      wdog        <= wdog_n;
      if (!error && code_n != 3'd0) begin
        error    <= 1'b1;
        err_code <= code_n;
      end
    end
  end

  assign seg_state = seg_q;

`ifdef RVFI_COMMIT_LOG_EN
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NRET; k++) begin
        if (accept[k]) begin
          if (inst[k*32 +: 2] != 2'b11)
            $display("core   0: 3 0x%08h (0x%04h)", pc_rdata[k*32 +: 32],
                     inst[k*32 +: 16]);
          else
            $display("core   0: 3 0x%08h (0x%08h)", pc_rdata[k*32 +: 32],
                     inst[k*32 +: 32]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_multi_commit_monitor.sv
// Bench for rvfi_multi_commit_monitor: a vector table plus hand sequences for segment, halt and watchdog.
module tb_rvfi_multi_commit_monitor;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] START = 32'h0010_2013;
  localparam logic [31:0] STOP  = 32'h0020_2013;
  localparam logic [31:0] JSELF = 32'h0000_006f;

  typedef struct packed {
    logic        h;
    logic        e;
    logic [2:0]  c;
    logic [1:0]  s;
    logic [63:0] ic;
    logic [63:0] cc;
  } exp_t;

  typedef struct {
    string       name;
    logic        r;
    logic [1:0]  v;
    logic [63:0] o0;
    logic [63:0] o1;
    logic [31:0] i0;
    logic [31:0] i1;
    exp_t        e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   valid;
  logic [127:0] order;
  logic [63:0]  inst, pc_rdata, pc_wdata;
  logic         halt, error;
  logic [2:0]   err_code;
  logic [1:0]   seg_state;
  logic [63:0]  inst_count, cycle_count;

  int n_vec = 0;
  int n_bad = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  rvfi_multi_commit_monitor #(
    .NRET(2), .ORDER_W(64), .CNT_W(64), .WDOG_CYC(16),
    .SEG_START(START), .SEG_STOP(STOP)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .order(order), .inst(inst),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .halt(halt), .error(error),
    .err_code(err_code), .seg_state(seg_state), .inst_count(inst_count),
    .cycle_count(cycle_count)
  );

  function automatic exp_t mk(input logic h, input logic e, input logic [2:0] c,
                              input logic [1:0] s, input logic [63:0] ic,
                              input logic [63:0] cc);
    exp_t x;
    x.h = h; x.e = e; x.c = c; x.s = s; x.ic = ic; x.cc = cc;
    return x;
  endfunction

  task automatic check();
    exp_t  w, g;
    string nm;
    w  = exp_q.pop_front();
    nm = name_q.pop_front();
    g  = mk(halt, error, err_code, seg_state, inst_count, cycle_count);
    n_vec++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL %s: got halt=%0d err=%0d code=%0d seg=%0d ic=%0d cc=%0d, want halt=%0d err=%0d code=%0d seg=%0d ic=%0d cc=%0d",
               nm, g.h, g.e, g.c, g.s, g.ic, g.cc, w.h, w.e, w.c, w.s, w.ic, w.cc);
    end
  endtask

  // pcs[k] makes lane k's next PC equal its own PC (self-loop halt).
  task automatic step(input string nm, input logic r, input logic [1:0] v,
                      input logic [63:0] o0, input logic [63:0] o1,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] pcs, input exp_t e);
    @(negedge clk);
    rst      = r;
    valid    = v;
    order    = {o1, o0};
    inst     = {i1, i0};
    pc_rdata = {32'h0000_1004, 32'h0000_1000};
    pc_wdata = {pcs[1] ? 32'h0000_1004 : 32'h0000_1008,
                pcs[0] ? 32'h0000_1000 : 32'h0000_1004};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check();
  endtask

  vec_t tbl[11];

  initial begin
    logic [1:0]  pat [7];
    logic [63:0] ord, ic;

    rst = 1'b1; valid = '0; order = '0; inst = '0; pc_rdata = '0; pc_wdata = '0;

    tbl[0]  = '{"reset",          1'b1, 2'b00, 64'd0, 64'd0, NOP, NOP, mk(0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{"pair01",         1'b0, 2'b11, 64'd0, 64'd1, NOP, NOP, mk(0, 0, 0, 0, 2, 1)};
    tbl[2]  = '{"pair23",         1'b0, 2'b11, 64'd2, 64'd3, NOP, NOP, mk(0, 0, 0, 0, 4, 2)};
    tbl[3]  = '{"lane0_ord4",     1'b0, 2'b01, 64'd4, 64'd0, NOP, NOP, mk(0, 0, 0, 0, 5, 3)};
    tbl[4]  = '{"lane_gap",       1'b0, 2'b10, 64'd0, 64'd5, NOP, NOP, mk(0, 1, 1, 0, 6, 4)};
    tbl[5]  = '{"gap_sticky",     1'b0, 2'b11, 64'd6, 64'd7, NOP, NOP, mk(0, 1, 1, 0, 8, 5)};
    tbl[6]  = '{"reset2",         1'b1, 2'b11, 64'd0, 64'd1, NOP, NOP, mk(0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{"gap_and_order",  1'b0, 2'b10, 64'd0, 64'd7, NOP, NOP, mk(0, 1, 1, 0, 1, 1)};
    tbl[8]  = '{"reset3",         1'b1, 2'b00, 64'd0, 64'd0, NOP, NOP, mk(0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{"order_skip",     1'b0, 2'b11, 64'd0, 64'd5, NOP, NOP, mk(0, 1, 2, 0, 2, 1)};
    tbl[10] = '{"order_sticky",   1'b0, 2'b10, 64'd0, 64'd6, NOP, NOP, mk(0, 1, 2, 0, 3, 2)};

    for (int i = 0; i < 11; i++)
      step(tbl[i].name, tbl[i].r, tbl[i].v, tbl[i].o0, tbl[i].o1, tbl[i].i0, tbl[i].i1,
           2'b00, tbl[i].e);

    // Watchdog trips during this stall, but the earlier order error stays recorded.
    for (int i = 1; i <= 16; i++)
      step("wdog_after_order", 1'b0, 2'b00, 0, 0, NOP, NOP, 2'b00,
           mk(0, 1, 2, 0, 3, 64'(2 + i)));

    // Segment: stop marker outside SEG ignored, start at lane 1, stop at lane 0.
    step("seg_reset", 1'b1, 2'b00, 0, 0, NOP, NOP, 2'b00, mk(0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      step("seg_free", 1'b0, 2'b01, 64'(k - 1), 0, (k == 3) ? STOP : NOP, NOP, 2'b00,
           mk(0, 0, 0, 0, 64'(k), 64'(k)));
    step("seg_start_l1", 1'b0, 2'b11, 9, 10, NOP, START, 2'b00, mk(0, 0, 0, 1, 0, 0));
    pat = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01};
    ord = 11;
    ic  = 0;
    for (int j = 0; j < 7; j++) begin
      ic = ic + 64'(pat[j][0]) + 64'(pat[j][1]);
      step("seg_run", 1'b0, pat[j], ord, ord + 1, NOP, NOP, 2'b00,
           mk(0, 0, 0, 1, ic, 64'(j + 1)));
      ord = ord + 64'(pat[j][0]) + 64'(pat[j][1]);
    end
    step("seg_stop_l0", 1'b0, 2'b01, ord, 0, STOP, NOP, 2'b00, mk(0, 0, 0, 2, 7, 8));
    ord = ord + 1;
    step("seg_frozen", 1'b0, 2'b11, ord, ord + 1, NOP, NOP, 2'b00, mk(0, 0, 0, 2, 7, 8));
    ord = ord + 2;
    step("start_stop_same", 1'b0, 2'b11, ord, ord + 1, START, STOP, 2'b00,
         mk(0, 0, 0, 2, 1, 0));

    // Halt on jump-to-self in lane 0: lane 1 ignored, later commit is error 4.
    step("halt_reset", 1'b1, 2'b00, 0, 0, NOP, NOP, 2'b00, mk(0, 0, 0, 0, 0, 0));
    step("halt_jself", 1'b0, 2'b11, 0, 1, JSELF, NOP, 2'b00, mk(1, 0, 0, 0, 1, 1));
    step("commit_after_halt", 1'b0, 2'b01, 1, 0, NOP, NOP, 2'b00, mk(1, 1, 4, 0, 1, 1));
    step("halt_hold", 1'b0, 2'b00, 0, 0, NOP, NOP, 2'b00, mk(1, 1, 4, 0, 1, 1));

    // Halt via pc_rdata==pc_wdata on lane 1; watchdog and counters frozen afterwards.
    step("pc_halt_reset", 1'b1, 2'b00, 0, 0, NOP, NOP, 2'b00, mk(0, 0, 0, 0, 0, 0));
    step("pc_halt_l1", 1'b0, 2'b11, 0, 1, NOP, NOP, 2'b10, mk(1, 0, 0, 0, 2, 1));
    for (int i = 0; i < 20; i++)
      step("wdog_frozen", 1'b0, 2'b00, 0, 0, NOP, NOP, 2'b00, mk(1, 0, 0, 0, 2, 1));

    // Watchdog boundary: quiet for 15 cycles, trips on the 16th.
    step("wdog_reset", 1'b1, 2'b00, 0, 0, NOP, NOP, 2'b00, mk(0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 16; i++)
      step("wdog_count", 1'b0, 2'b00, 0, 0, NOP, NOP, 2'b00,
           mk(0, (i == 16), (i == 16) ? 3'd3 : 3'd0, 0, 0, 64'(i)));
    step("seg_after_wdog", 1'b0, 2'b01, 0, 0, START, NOP, 2'b00, mk(0, 1, 3, 1, 0, 0));
    step("seg_active", 1'b0, 2'b11, 1, 2, NOP, NOP, 2'b00, mk(0, 1, 3, 1, 2, 1));
    step("rst_mid_seg", 1'b1, 2'b00, 0, 0, NOP, NOP, 2'b00, mk(0, 0, 0, 0, 0, 0));
    step("free_after_rst", 1'b0, 2'b01, 0, 0, NOP, NOP, 2'b00, mk(0, 0, 0, 0, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
